md_sched: RTL

Multiply/divide scheduler for the five-stage pipeline. It owns the HI/LO register pair and sequences multi-cycle MULT/MULTU/DIV/DIVU operations issued from the E stage. It accepts MTHI/MTLO writes and exposes HI/LO to the MFHI/MFLO path. It raises a stall request that the stall controller ORs into its freeze of PC/D and its bubble into E, whenever the instruction in D needs the unit while it is busy.

---
 rtl/md_sched.sv | 109 ++++++++++
 1 files changed

// File: rtl/md_sched.sv
// md_sched: HI/LO owner and multi-cycle mult/div sequencer.
// Result is computed at issue, held pending, committed after N busy cycles.
module md_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_in_D,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall_md
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] phi_q, plo_q;
  logic [31:0] hi_q, lo_q;
  logic        busy_q;

  logic [63:0] res_d;
  logic [63:0] sa, sb, smul, umul;
  logic        sgn, rs_neg, rt_neg;
  logic [31:0] rs_abs, rt_abs, den;
  logic [31:0] q_abs, r_abs, q, r;

  // Result of the op presented this cycle, latched only on issue.
  always_comb begin
    sa     = {{32{rs_val[31]}}, rs_val};
    sb     = {{32{rt_val[31]}}, rt_val};
    smul   = sa * sb;
    umul   = {32'd0, rs_val} * {32'd0, rt_val};
    sgn    = ~op[0];
    rs_neg = sgn & rs_val[31];
    rt_neg = sgn & rt_val[31];
    rs_abs = rs_neg ? (~rs_val + 32'd1) : rs_val;
    rt_abs = rt_neg ? (~rt_val + 32'd1) : rt_val;
    den    = (rt_val == 32'd0) ? 32'd1 : rt_abs;
    q_abs  = rs_abs / den;
    r_abs  = rs_abs % den;
    q      = (rs_neg ^ rt_neg) ? (~q_abs + 32'd1) : q_abs;
    r      = rs_neg ? (~r_abs + 32'd1) : r_abs;
    res_d  = 64'd0;
    unique case (op[1:0])
      2'd0: res_d = smul;
      2'd1: res_d = umul;
      default: begin
        if (rt_val == 32'd0) res_d = {rs_val, 32'hFFFF_FFFF};
        else                 res_d = {r, q};
      end
    endcase
  end

  // Issue, countdown and commit; MTHI/MTLO write directly when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !op[2]) begin
            {phi_q, plo_q} <= res_d;
            cnt_q   <= op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            state_q <= RUN;
            busy_q  <= 1'b1;
          end else if (start && op == 3'd4) begin
            hi_q <= rs_val;
          end else if (start && op == 3'd5) begin
            lo_q <= rs_val;
          end
        end
        RUN: begin
          if (cnt_q == 4'd1) begin
            hi_q    <= phi_q;
            lo_q    <= plo_q;
            cnt_q   <= 4'd0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign stall_md = md_in_D & (busy_q | (start & ~op[2]));

endmodule
